frog_move_scheduler: RTL

Turns the held-direction levels from the keyboard command decoder into discrete one-hop move commands for the frog game logic. Adds typematic auto-repeat, timed in video frames, and resolves simultaneous keys with a fixed priority. Each move is handed to the game logic over a req/ack handshake. Sits between the keyboard decoder and the frog position/move logic.

---
 rtl/frog_move_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/frog_move_scheduler.sv
// frog_move_scheduler
// Converts held direction-key levels into discrete one-hop move commands.
// Adds frame-timed typematic auto-repeat, fixed key priority
// (up > down > left > right) and a req/ack handshake toward the game logic.

module frog_move_scheduler #(
  parameter int INITIAL_DELAY = 15,  // frames from first accepted move to first repeat (1..63)
  parameter int REPEAT_PERIOD = 8    // frames between later repeats (1..63)
) (
  input  logic       clk,
  input  logic       resetN,         // asynchronous, active-high despite the name
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       move_ack,
  output logic       move_req,
  output logic [1:0] move_dir,
  output logic [7:0] move_count
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] ISSUE       = 2'd1;
  localparam logic [1:0] WAIT_FIRST  = 2'd2;
  localparam logic [1:0] WAIT_REPEAT = 2'd3;

  localparam logic [5:0] INIT_CNT = 6'(INITIAL_DELAY);
  localparam logic [5:0] REP_CNT  = 6'(REPEAT_PERIOD);

  logic [1:0] state;
  logic [1:0] dir_r;
  logic [5:0] cnt;
  logic       first;
  logic [3:0] keys_d;

  logic [3:0] keys;
  logic [3:0] rise;
  logic       new_key;
  logic       dir_held;
  logic       any_key;
  logic [1:0] sel_dir;

  // Bit index equals the move_dir encoding, so dir_r indexes keys directly.
  assign keys     = {right, left, down, up};
  assign rise     = keys & ~keys_d;
  assign new_key  = |(rise & ~(4'b0001 << dir_r));
  assign dir_held = keys[dir_r];
  assign any_key  = |keys;

  // Fixed-priority selection of the held key; only consumed when any_key is set.
  always_comb begin
    // NOTE: default first so every path assigns sel_dir and no latch is inferred.
    sel_dir = 2'd3;
    if (up)        sel_dir = 2'd0;
    else if (down) sel_dir = 2'd1;
    else if (left) sel_dir = 2'd2;
  end

  // Key history for rising-edge detection.
  always_ff @(posedge clk or posedge resetN) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (resetN) keys_d <= '0;
    else        keys_d <= keys;
  end

  // Move FSM: select, issue with handshake, then count frames to the next repeat.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state      <= IDLE;
      dir_r      <= 2'd0;
      cnt        <= '0;
      first      <= 1'b0;
      move_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any_key) begin
            dir_r <= sel_dir;
            first <= 1'b1;
            state <= ISSUE;
          end
        end

        // The committed move stays up until acked even if the key is released.
        // A frame tick coinciding with the ack is ignored: counting starts at the reload.
        ISSUE: begin
          if (move_ack) begin
            move_count <= move_count + 8'd1;
            first      <= 1'b0;
            if (first) begin
              state <= WAIT_FIRST;
              cnt   <= INIT_CNT;
            end else begin
              state <= WAIT_REPEAT;
              cnt   <= REP_CNT;
            end
          end
        end

        // Release beats expiry; a newly pressed other key restarts selection.
        WAIT_FIRST, WAIT_REPEAT: begin
          if (!dir_held) begin
            state <= IDLE;
          end else if (new_key) begin
            state <= IDLE;
          end else if (startOfFrame) begin
            if (cnt <= 6'd1) state <= ISSUE;
            else             cnt   <= cnt - 6'd1;
          end
        end

        default: state <= IDLE;
      endcase

      // NOTE: later non-blocking assignment wins, so this override beats the case above;
      // an ack coinciding with enable low is still counted.
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  assign move_req = (state == ISSUE);
  assign move_dir = dir_r;

endmodule
